// File: rtl/branch_predictor_if.sv
// Signal bundle between the pipeline and the branch predictor.
// The master side is the pipeline: it presents the fetch PC and the resolved
// branch from MEM. The slave side is the predictor: it returns the
// prediction metadata and the mispredict/redirect decision.
interface branch_predictor_if #(
  parameter int INDEX_W = 4
);
  // Fetch-side lookup
  logic [31:0]        if_pc;
  logic               if_predict;
  logic [INDEX_W-1:0] if_index;
  logic [31:0]        if_target;

  // MEM-side training input
  logic               upd_en;
  logic [INDEX_W-1:0] upd_index;
  logic [31:0]        upd_pc_plus4;
  logic               upd_predict;
  logic [31:0]        upd_pred_target;
  logic               upd_taken;
  logic [31:0]        upd_target;

  // Redirect back to fetch
  logic               mispredict;
  logic [31:0]        redirect_pc;

  modport master (
    output if_pc,
    output upd_en, upd_index, upd_pc_plus4, upd_predict,
    output upd_pred_target, upd_taken, upd_target,
    input  if_predict, if_index, if_target,
    input  mispredict, redirect_pc
  );

  modport slave (
    input  if_pc,
    input  upd_en, upd_index, upd_pc_plus4, upd_predict,
    input  upd_pred_target, upd_taken, upd_target,
    output if_predict, if_index, if_target,
    output mispredict, redirect_pc
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
//
// Lookup is purely combinational on the fetch PC. Training happens at the
// clock edge from the branch resolved in MEM; a lookup of the entry being
// trained in the same cycle sees the old contents (no bypass).
//
// Optional feature: define BP_PERF_CNT_EN to add the perf_branches and
// perf_mispred event counters. Without it those ports and their logic are
// absent and the predictor behaves identically.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 30 - INDEX_W
) (
  input  logic               CLK,
  input  logic               RST,
  branch_predictor_if.slave  bp
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0]        perf_branches,
  output logic [31:0]        perf_mispred
`endif
);

  // Per-entry direction counter: strongly/weakly not-taken, weakly/strongly taken.
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    ctr_e             ctr;
  } entry_t;

  entry_t table_q [ENTRIES];

  // ---------------------------------------------------------------------------
  // Lookup
  // ---------------------------------------------------------------------------
  logic [INDEX_W-1:0] lk_index;
  logic [TAG_W-1:0]   lk_tag;
  entry_t             lk_entry;
  logic               lk_hit;

  assign lk_index = bp.if_pc[INDEX_W+1:2];
  assign lk_tag   = bp.if_pc[31:INDEX_W+2];
  assign lk_entry = table_q[lk_index];
  assign lk_hit   = lk_entry.valid && (lk_entry.tag == lk_tag);

  assign bp.if_index   = lk_index;
  assign bp.if_predict = lk_hit & lk_entry.ctr[1];
  assign bp.if_target  = lk_hit ? lk_entry.target : 32'd0;

  // ---------------------------------------------------------------------------
  // Mispredict / redirect
  // ---------------------------------------------------------------------------
  // A taken branch predicted taken is still wrong if it went somewhere else.
  logic dir_wrong;
  logic tgt_wrong;

  assign dir_wrong = bp.upd_taken != bp.upd_predict;
  assign tgt_wrong = bp.upd_taken & bp.upd_predict &
                     (bp.upd_pred_target != bp.upd_target);

  assign bp.mispredict  = bp.upd_en & (dir_wrong | tgt_wrong);
  assign bp.redirect_pc = bp.upd_taken ? bp.upd_target : bp.upd_pc_plus4;

  // ---------------------------------------------------------------------------
  // Training
  // ---------------------------------------------------------------------------
  // The branch's own PC is recovered from pc+4 to form its tag; the index
  // travels with the branch so it is taken as given.
  logic [31:0]      upd_pc;
  logic [TAG_W-1:0] upd_tag;
  entry_t           upd_cur;
  logic             upd_hit;
  ctr_e             ctr_nxt;
  entry_t           upd_next;
  logic             upd_we;

  assign upd_pc  = bp.upd_pc_plus4 - 32'd4;
  assign upd_tag = upd_pc[31:INDEX_W+2];
  assign upd_cur = table_q[bp.upd_index];
  assign upd_hit = upd_cur.valid && (upd_cur.tag == upd_tag);

  // Counter FSM next state: step toward the outcome, saturating at both ends.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // that no path leaves it unassigned, which would infer a latch.
    ctr_nxt = upd_cur.ctr;
    case (upd_cur.ctr)
      CTR_SNT: ctr_nxt = bp.upd_taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: ctr_nxt = bp.upd_taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  ctr_nxt = bp.upd_taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  ctr_nxt = bp.upd_taken ? CTR_ST  : CTR_WT;
      default: ctr_nxt = CTR_WNT;
    endcase
  end

  // Entry next state: train on a hit, allocate only on a taken miss.
  always_comb begin
    upd_next = upd_cur;
    upd_we   = 1'b0;
    if (bp.upd_en) begin
      if (upd_hit) begin
        upd_we       = 1'b1;
        upd_next.ctr = ctr_nxt;
        if (bp.upd_taken) begin
          upd_next.target = bp.upd_target;
        end
      end else if (bp.upd_taken) begin
        upd_we          = 1'b1;
        upd_next.valid  = 1'b1;
        upd_next.tag    = upd_tag;
        upd_next.target = bp.upd_target;
        upd_next.ctr    = CTR_WT;
      end
    end
  end

  // Table state register: reset empties every entry and wins over training.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: the table is built from flops, not a RAM macro, so every entry
      // can and must be cleared here; a RAM could not be reset this way.
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
      end
    end else if (upd_we) begin
      // NOTE: state is written with <= so that every reader in this cycle,
      // including the same-index lookup, sees the pre-edge contents.
      table_q[bp.upd_index] <= upd_next;
    end
  end

`ifdef BP_PERF_CNT_EN
  // Event counters for resolved branches and mispredictions; wrap modulo 2^32.
  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_branches <= '0;
      perf_mispred  <= '0;
    end else begin
      if (bp.upd_en) begin
        perf_branches <= perf_branches + 32'd1;
      end
      if (bp.mispredict) begin
        perf_mispred <= perf_mispred + 32'd1;
      end
    end
  end
`endif

  // Byte-offset and index bits not used by the tag compares.
  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, bp.if_pc[1:0], upd_pc[INDEX_W+1:0]};

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- 16-entry direct-mapped branch target buffer with 2-bit saturating counters.
- Sits beside the fetch stage. Each cycle it produces the prediction metadata (predict, index, br_target) that travels down the IF/ID, ID/EX and EX/MEM registers.
- Consumes the resolved branch outcome in the MEM stage, trains the table, and raises mispredict/redirect.

Parameters:
- ENTRIES, 16, number of BTB entries; must be a power of 2.
- INDEX_W, 4, log2(ENTRIES); index = pc[INDEX_W+1:2].
- TAG_W, 26, tag = pc[31:INDEX_W+2]; TAG_W = 30-INDEX_W.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous active-high reset.
- if_pc  in  32  current fetch PC.
- if_predict  out  1  predicted taken for if_pc.
- if_index  out  INDEX_W  table index of if_pc; carried down the pipe.
- if_target  out  32  predicted target (br_target field).
- upd_en  in  1  resolved branch in MEM this cycle (bra!=0 and pipeline not stalled).
- upd_index  in  INDEX_W  index carried with the branch.
- upd_pc_plus4  in  32  pc+4 of the branch.
- upd_predict  in  1  prediction made at fetch.
- upd_pred_target  in  32  br_target made at fetch.
- upd_taken  in  1  actual outcome (BEQ: zero; BNE: !zero).
- upd_target  in  32  actual computed branch target.
- mispredict  out  1  redirect and flush IF/ID/EX.
- redirect_pc  out  32  correct next PC when mispredict=1.

Behaviour:
- Storage per entry: valid, tag[TAG_W], target[32], ctr[2]. All entries are flops; no memory macro.
- Reset (RST high at a CLK edge): all valid=0, all ctr=2'b01, all tag/target=0.
- Reset overrides any update in the same cycle. Reset mid-run simply empties the table.
- Lookup (combinational, zero latency):
  - hit = valid[idx] & (tag[idx]==if_pc[31:INDEX_W+2]).
  - if_predict = hit & ctr[idx][1].
  - if_target = hit ? target[idx] : 0.
  - if_index = if_pc[INDEX_W+1:2] always.
- Mispredict (combinational on update inputs, valid only when upd_en=1; 0 otherwise):
  - mispredict = upd_en & ((upd_taken != upd_predict) | (upd_taken & upd_predict & upd_pred_target != upd_target)).
  - redirect_pc = upd_taken ? upd_target : upd_pc_plus4. Value is don't-care-free: it is always driven by this formula, even when mispredict=0.
- Update (registered at the CLK edge when upd_en=1). Entry = upd_index; utag = (upd_pc_plus4-4)[31:INDEX_W+2]; uhit = valid & tag==utag.
  - uhit & taken: ctr = min(ctr+1, 3); target = upd_target.
  - uhit & !taken: ctr = max(ctr-1, 0); target unchanged.
  - !uhit & taken: allocate/replace: valid=1, tag=utag, target=upd_target, ctr=2'b10.
  - !uhit & !taken: no change; no allocation.
- Counter wrap is forbidden: it saturates at 3 and at 0.
- Simultaneous lookup and update of the same index: lookup returns pre-update contents (no bypass). The new state is visible on the next cycle.
- Only one update per cycle. upd_en held high across a stall would be a protocol error; the caller gates it with the stall.
- State machine: the per-entry counter FSM is SNT(00) <-> WNT(01) <-> WT(10) <-> ST(11), stepped by the outcome.

Optional Feature:
- BP_PERF_CNT_EN defined:
  - Adds outputs perf_branches[31:0] and perf_mispred[31:0].
  - perf_branches increments on each upd_en; perf_mispred increments on each mispredict.
  - Both clear on RST and wrap modulo 2^32.
- BP_PERF_CNT_EN undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset then if_pc=0x0000_0040 -> if_predict=0, if_target=0, if_index=0.
- upd_en, pc_plus4=0x44, idx 0, taken=1, predict=0, target=0x100 -> mispredict=1, redirect_pc=0x100. Next cycle if_pc=0x40 -> if_predict=1, if_target=0x100 (ctr=10).
- From ctr=10: two taken updates -> ctr=11. A third taken update keeps ctr=11. Then two not-taken updates -> ctr=01 and if_predict=0. The second not-taken update, with predict=1, gives mispredict=1 and redirect_pc=0x44.
- Aliasing: entry idx 0 holds tag of 0x40; lookup if_pc=0x80 (same idx, different tag) -> if_predict=0. Taken update for 0x80, target 0x200 -> entry replaced, ctr=10, and 0x40 now misses.
- Same-cycle update and lookup of idx 3 on an empty table -> lookup if_predict=0 that cycle, 1 the next.
- RST asserted in the same cycle as upd_en taken -> table stays empty; the next lookup misses. With BP_PERF_CNT_EN, both counters read 0.
